// File: rtl/jrb8_prog_loader.sv
// Boot loader for JRB8: receives a length-prefixed, checksummed image over a
// strobe handshake, writes it into program RAM and then releases the CPU.
module jrb8_prog_loader #(
   parameter int         ADDR_W      = 8,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] CMD_LOAD    = 8'hA5,
   parameter logic [7:0] CMD_RUN     = 8'h5A
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_strb,
   input  logic [7:0]        ld_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_run,
   output logic              busy,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_RUN,
      S_ERR
   } state_t;

   state_t                  state_reg;
   logic [SYNC_STAGES-1:0]  sync_reg;
   logic [SYNC_STAGES-1:0]  fill_reg;
   logic                    prev_reg;
   logic                    armed_reg;
   logic [8:0]              cnt_reg;
   logic [ADDR_W-1:0]       addr_reg;
   logic [7:0]              sum_reg;
   logic                    mem_we_reg;
   logic [ADDR_W-1:0]       mem_addr_reg;
   logic [7:0]              mem_wdata_reg;
   logic                    cpu_run_reg;
   logic                    busy_reg;
   logic                    err_reg;

   logic synced;
   logic sync_valid;
   logic ev;

   assign synced     = sync_reg[SYNC_STAGES-1];
   // The cleared chain reads low right after reset; fill_reg keeps those
   // flushed zeros from arming the detector, so a strobe held high gives no event.
   assign sync_valid = fill_reg[SYNC_STAGES-1];
   assign ev         = armed_reg & synced & ~prev_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg  <= '0;
         fill_reg  <= '0;
         prev_reg  <= 1'b0;
         armed_reg <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[SYNC_STAGES-2:0], ld_strb};
         fill_reg  <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
         prev_reg  <= synced;
         armed_reg <= armed_reg | (sync_valid & ~synced);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         addr_reg      <= '0;
         sum_reg       <= '0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         cpu_run_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         mem_we_reg <= 1'b0;
         case (state_reg)
            S_IDLE, S_ERR: begin
               if (ev) begin
                  if (ld_data == CMD_LOAD) begin
                     state_reg <= S_LEN;
                     busy_reg  <= 1'b1;
                     err_reg   <= 1'b0;
                  end else if (ld_data == CMD_RUN) begin
                     state_reg   <= S_RUN;
                     cpu_run_reg <= 1'b1;
                  end
               end
            end
            S_LEN: begin
               if (ev) begin
                  // A length byte of zero encodes 256.
                  cnt_reg   <= {(ld_data == 8'd0), ld_data};
                  addr_reg  <= '0;
                  sum_reg   <= '0;
                  state_reg <= S_DATA;
               end
            end
            S_DATA: begin
               if (ev) begin
                  mem_we_reg    <= 1'b1;
                  mem_addr_reg  <= addr_reg;
                  mem_wdata_reg <= ld_data;
                  addr_reg      <= addr_reg + 1'b1;
                  sum_reg       <= sum_reg + ld_data;
                  cnt_reg       <= cnt_reg - 9'd1;
                  if (cnt_reg == 9'd1)
                     state_reg <= S_CSUM;
               end
            end
            S_CSUM: begin
               if (ev) begin
                  busy_reg <= 1'b0;
                  if (8'(sum_reg + ld_data) == 8'd0) begin
                     state_reg   <= S_RUN;
                     cpu_run_reg <= 1'b1;
                     err_reg     <= 1'b0;
                  end else begin
                     state_reg <= S_ERR;
                     err_reg   <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               cpu_run_reg <= 1'b1;
            end
            default: begin
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign cpu_run   = cpu_run_reg;
   assign busy      = busy_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_jrb8_prog_loader.sv
// Scoreboard bench for jrb8_prog_loader: expected RAM writes are queued as bytes
// are sent and matched by a monitor on every mem_we pulse.
module tb_jrb8_prog_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       ld_strb;
   logic [7:0] ld_data;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_run;
   logic       busy;
   logic       err;

   logic [15:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_wr  = 0;
   logic        prev_we = 1'b0;

   jrb8_prog_loader dut (
      .clk       (clk),
      .rst       (rst),
      .ld_strb   (ld_strb),
      .ld_data   (ld_data),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_run   (cpu_run),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Write monitor: every pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (mem_we) begin
         logic [15:0] e;
         n_wr++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got addr=%02h data=%02h, required no write",
                     mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               n_bad++;
               $display("FAIL write: got addr=%02h data=%02h, required addr=%02h data=%02h",
                        mem_addr, mem_wdata, e[15:8], e[7:0]);
            end else if (n_wr <= 8 || n_wr % 64 == 0) begin
               $display("write %0d: addr=%02h data=%02h", n_wr, mem_addr, mem_wdata);
            end
         end
         n_cmp++;
         if (prev_we) begin
            n_bad++;
            $display("FAIL we_spacing: got mem_we high two cycles in a row, required single pulse");
         end
      end
      prev_we = mem_we;
   end

   task automatic do_reset(input logic strb);
      rst     = 1'b1;
      ld_strb = strb;
      ld_data = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 ld_data = b;
      #2 ld_strb = 1'b1;
      repeat (6) @(posedge clk);
      #1 ld_strb = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      $display("sent byte %02h: cpu_run=%0b busy=%0b err=%0b", b, cpu_run, busy, err);
   endtask

   task automatic send_data(input logic [7:0] a, input logic [7:0] b);
      exp_q.push_back({a, b});
      send_byte(b);
   endtask

   task automatic check_flags(input string name, input logic run_e, input logic busy_e,
                              input logic err_e);
      n_cmp++;
      if ({cpu_run, busy, err} !== {run_e, busy_e, err_e}) begin
         n_bad++;
         $display("FAIL %s: got run/busy/err=%0b%0b%0b, required %0b%0b%0b",
                  name, cpu_run, busy, err, run_e, busy_e, err_e);
      end
   endtask

   task automatic check_drained(input string name);
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_bad++;
         $display("FAIL %s: got %0d writes outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_reset_outputs(input string name);
      @(negedge clk);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata, cpu_run, busy, err} !== 20'h0) begin
         n_bad++;
         $display("FAIL %s: got we=%0b addr=%02h wdata=%02h run=%0b busy=%0b err=%0b, required all 0",
                  name, mem_we, mem_addr, mem_wdata, cpu_run, busy, err);
      end
   endtask

   task automatic test_reset;
      do_reset(1'b1);
      repeat (20) @(posedge clk);
      check_reset_outputs("reset_strobe_high");
      check_drained("reset_no_writes");
      ld_strb = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check_flags("reset_idle", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_load_ok;
      do_reset(1'b0);
      send_byte(8'hA5);
      check_flags("ok_after_cmd", 1'b0, 1'b1, 1'b0);
      send_byte(8'h03);
      send_data(8'h00, 8'h11);
      send_data(8'h01, 8'h22);
      send_data(8'h02, 8'h33);
      check_flags("ok_before_csum", 1'b0, 1'b1, 1'b0);
      send_byte(8'h9A);
      check_drained("ok_writes");
      check_flags("ok_final", 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_csum_fail_retry;
      do_reset(1'b0);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_data(8'h00, 8'h10);
      send_byte(8'h00);
      check_drained("fail_writes");
      check_flags("fail_err", 1'b0, 1'b0, 1'b1);
      send_byte(8'h33);
      check_flags("fail_ignore", 1'b0, 1'b0, 1'b1);
      send_byte(8'hA5);
      check_flags("retry_cmd_clears_err", 1'b0, 1'b1, 1'b0);
      send_byte(8'h01);
      send_data(8'h00, 8'h10);
      send_byte(8'hF0);
      check_drained("retry_writes");
      check_flags("retry_final", 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_len_256;
      do_reset(1'b0);
      send_byte(8'hA5);
      send_byte(8'h00);
      for (int i = 0; i < 256; i++)
         send_data(8'(i), 8'h01);
      check_flags("len256_before_csum", 1'b0, 1'b1, 1'b0);
      send_byte(8'h00);
      check_drained("len256_writes");
      check_flags("len256_final", 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_run_cmd;
      do_reset(1'b0);
      send_byte(8'h77);
      check_flags("run_ignore_77", 1'b0, 1'b0, 1'b0);
      send_byte(8'h5A);
      check_flags("run_released", 1'b1, 1'b0, 1'b0);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h44);
      check_drained("run_no_writes");
      check_flags("run_sticky", 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_mid_load_reset;
      do_reset(1'b0);
      send_byte(8'hA5);
      send_byte(8'h04);
      send_data(8'h00, 8'hAA);
      check_drained("mid_first_write");
      rst = 1'b1;
      repeat (2) @(posedge clk);
      check_reset_outputs("mid_reset_outputs");
      #1 rst = 1'b0;
      send_byte(8'hBB);
      check_drained("mid_no_writes");
      check_flags("mid_idle", 1'b0, 1'b0, 1'b0);
      send_byte(8'hA5);
      check_flags("mid_restart", 1'b0, 1'b1, 1'b0);
      send_byte(8'h01);
      send_data(8'h00, 8'h55);
      send_byte(8'hAB);
      check_drained("mid_restart_writes");
      check_flags("mid_restart_final", 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      rst     = 1'b1;
      ld_strb = 1'b0;
      ld_data = 8'h00;
      test_reset();
      test_load_ok();
      test_csum_fail_retry();
      test_len_256();
      test_run_cmd();
      test_mid_load_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
